rom_download_ctrl: RTL and testbench

//  Sequences the HPS ioctl download stream into the arcade core: routes index-0 bytes to the ROM write port,

---
 rtl/rom_download_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rom_download_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_ctrl.sv
// -----------------------------------------------------------------------------
// rom_download_ctrl
//
// Purpose:
//   Sequences the HPS ioctl download stream into the arcade core.
//     - index 0   : ROM bytes, queued in a small first-word-fall-through FIFO
//                   so a slow ROM/SDRAM port can apply backpressure.
//     - index 1   : game-select byte (last write wins).
//     - index 254 : DIP switch bank, eight bytes at addresses 0..7.
//   Keeps the core in reset while a download runs, while the ROM FIFO drains,
//   and for a fixed hold time afterwards. After that the core runs under the
//   control of the (registered) user reset request.
//
// Parameters:
//   ROM_AW       ROM write address width
//   ROM_SIZE     index-0 bytes at addresses >= ROM_SIZE are dropped
//   FIFO_DEPTH   ROM write FIFO entries (power of two, >= 2)
//   HOLD_CYCLES  core reset hold after the FIFO has drained (>= 1)
//
// Ports:
//   clk_sys         in   system clock
//   reset           in   synchronous, active-high reset
//   user_reset      in   menu/button reset request (level)
//   ioctl_download  in   download active
//   ioctl_wr        in   one-cycle byte strobe, cannot be stalled
//   ioctl_index     in   stream index
//   ioctl_addr      in   byte address within the stream
//   ioctl_dout      in   byte data
//   dn_addr         out  ROM write address (FIFO head)
//   dn_data         out  ROM write data (FIFO head)
//   dn_wr           out  ROM write valid (FIFO not empty)
//   dn_ready        in   ROM port accepts; a transfer is dn_wr & dn_ready
//   game_id         out  selected game number
//   dip_sw          out  DIP bank, byte k at bits [8k+7:8k]
//   core_reset      out  reset to the arcade core
//   rom_loaded      out  at least one complete ROM download has been seen
//   fifo_ovf        out  sticky: a ROM byte was lost on a full FIFO
// -----------------------------------------------------------------------------
module rom_download_ctrl #(
  parameter int ROM_AW      = 16,
  parameter int ROM_SIZE    = 32'h0000_C000,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              user_reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  input  logic              dn_ready,
  output logic [7:0]        game_id,
  output logic [63:0]       dip_sw,
  output logic              core_reset,
  output logic              rom_loaded,
  output logic              fifo_ovf
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [24:0]       ROM_LIMIT = 25'(ROM_SIZE);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ROM_AW-1:0] ADDR_ZERO = {ROM_AW{1'b0}};

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_GAME = 8'd1;
  localparam logic [7:0] IDX_DIP  = 8'd254;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              state_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic                dl_prev_r;     // ioctl_download one cycle ago, for edge detect
  logic                pushed_r;      // an index-0 byte was queued in the current LOAD
  logic                core_reset_r;
  logic                rom_loaded_r;
  logic                fifo_ovf_r;
  logic [7:0]          game_id_r;
  logic [63:0]         dip_sw_r;

  logic [ROM_AW-1:0]   mem_addr_r [FIFO_DEPTH];
  logic [7:0]          mem_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;

  // ---------------------------------------------------------------------------
  // Strobe decode and FIFO handshake
  // ---------------------------------------------------------------------------
  logic strobe_s;
  logic rom_req_s;
  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;
  logic dl_rise_s;
  logic dl_fall_s;

  assign strobe_s  = ioctl_download & ioctl_wr;
  assign rom_req_s = strobe_s & (ioctl_index == IDX_ROM) & (ioctl_addr < ROM_LIMIT);
  assign empty_s   = (count_r == CNT_ZERO);
  assign full_s    = (count_r == CNT_FULL);
  assign pop_s     = ~empty_s & dn_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_s    = rom_req_s & (~full_s | pop_s);
  assign drop_s    = rom_req_s & full_s & ~pop_s;
  assign dl_rise_s = ioctl_download & ~dl_prev_r;
  assign dl_fall_s = ~ioctl_download & dl_prev_r;

  // ---------------------------------------------------------------------------
  // Outputs: FIFO head is presented directly (fall-through), the rest are
  // registers.
  // ---------------------------------------------------------------------------
  assign dn_wr      = ~empty_s;
  assign dn_addr    = mem_addr_r[rd_ptr_r];
  assign dn_data    = mem_data_r[rd_ptr_r];
  assign game_id    = game_id_r;
  assign dip_sw     = dip_sw_r;
  assign core_reset = core_reset_r;
  assign rom_loaded = rom_loaded_r;
  assign fifo_ovf   = fifo_ovf_r;

  // ROM write FIFO: storage, pointers and occupancy count.
  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_r[i] <= ADDR_ZERO;
        mem_data_r[i] <= 8'h00;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_addr_r[wr_ptr_r] <= ioctl_addr[ROM_AW-1:0];
        mem_data_r[wr_ptr_r] <= ioctl_dout;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Side-band registers: game select, DIP bank and the sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      game_id_r  <= 8'h00;
      dip_sw_r   <= 64'hFFFF_FFFF_FFFF_FFFF;
      fifo_ovf_r <= 1'b0;
    end else begin
      if (strobe_s && (ioctl_index == IDX_GAME)) begin
        game_id_r <= ioctl_dout;
      end
      // Only the first eight bytes of the DIP stream map onto the bank.
      if (strobe_s && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0)) begin
        dip_sw_r[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
      if (drop_s) begin
        fifo_ovf_r <= 1'b1;
      end
    end
  end

  // Download sequencer: state, hold counter, core reset and load status.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= ST_HOLD;
      hold_cnt_r   <= HOLD_LOAD;
      dl_prev_r    <= 1'b0;
      pushed_r     <= 1'b0;
      core_reset_r <= 1'b1;
      rom_loaded_r <= 1'b0;
    end else begin
      dl_prev_r <= ioctl_download;

      // A strobe in the very cycle the download rises belongs to the new LOAD.
      if (dl_rise_s) begin
        pushed_r <= push_s;
      end else if (push_s) begin
        pushed_r <= 1'b1;
      end

      // Core stays in reset everywhere except RUN, where it follows user_reset.
      core_reset_r <= 1'b1;

      // A new download preempts every state; queued ROM bytes are kept.
      if (dl_rise_s) begin
        state_r <= ST_LOAD;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_LOAD: begin
            if (dl_fall_s) begin
              state_r <= ST_DRAIN;
              if (pushed_r) begin
                rom_loaded_r <= 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (empty_s) begin
              state_r    <= ST_HOLD;
              hold_cnt_r <= HOLD_LOAD;
            end
          end
          ST_HOLD: begin
            if (hold_cnt_r == HOLD_ZERO) begin
              // Without a ROM the core must stay parked in reset.
              if (rom_loaded_r) begin
                state_r      <= ST_RUN;
                core_reset_r <= user_reset;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              hold_cnt_r <= hold_cnt_r - HOLD_ONE;
            end
          end
          ST_RUN: begin
            core_reset_r <= user_reset;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rom_download_ctrl
//
// Self-checking bench for rom_download_ctrl. A behavioural model (queue of
// pending ROM writes plus a few phase flags) is advanced on every rising edge
// and compared with the DUT on every falling edge. Directed scenarios add
// hand-computed literal expectations; a randomized section follows.
// -----------------------------------------------------------------------------
module tb_rom_download_ctrl;

  localparam int ROM_AW   = 16;
  localparam int ROM_SIZE = 32'h0000_C000;
  localparam int DEPTH    = 4;
  localparam int HOLD     = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              user_reset = 1'b0;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic [24:0]       ioctl_addr = 25'd0;
  logic [7:0]        ioctl_dout = 8'd0;
  logic [ROM_AW-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic              dn_ready = 1'b1;
  logic [7:0]        game_id;
  logic [63:0]       dip_sw;
  logic              core_reset;
  logic              rom_loaded;
  logic              fifo_ovf;

  rom_download_ctrl #(
    .ROM_AW      (ROM_AW),
    .ROM_SIZE    (ROM_SIZE),
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys        (clk),
    .reset          (reset),
    .user_reset     (user_reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .game_id        (game_id),
    .dip_sw         (dip_sw),
    .core_reset     (core_reset),
    .rom_loaded     (rom_loaded),
    .fifo_ovf       (fifo_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_mode = 1'b0;
  bit model_ok = 1'b0;

  // Observed ROM transfers, {addr, data}
  logic [23:0] wlog [$];

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [23:0] mq [$];          // pending ROM writes in order
  logic [7:0]  m_game;
  logic [63:0] m_dip;
  bit          m_loaded, m_ovf, m_core_reset;
  bit          m_prev_dl, m_loading, m_draining, m_running, m_pushed;
  int          m_hold_left;     // cycles of hold remaining, -1 when not holding

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_empty, pop, req, push_now, rise, fall;
    if (reset) begin
      mq.delete();
      m_game = 8'h00; m_dip = 64'hFFFF_FFFF_FFFF_FFFF;
      m_loaded = 1'b0; m_ovf = 1'b0; m_core_reset = 1'b1;
      m_prev_dl = 1'b0; m_loading = 1'b0; m_draining = 1'b0;
      m_running = 1'b0; m_pushed = 1'b0; m_hold_left = HOLD;
      model_ok = 1'b1;
      return;
    end
    was_empty = (mq.size() == 0);
    pop       = !was_empty && dn_ready;
    req       = ioctl_download && ioctl_wr && (ioctl_index == 8'd0) &&
                (int'(ioctl_addr) < ROM_SIZE);
    push_now  = req && ((mq.size() < DEPTH) || pop);
    if (req && !push_now) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push_now) mq.push_back({ioctl_addr[15:0], ioctl_dout});
    if (ioctl_download && ioctl_wr && ioctl_index == 8'd1) m_game = ioctl_dout;
    if (ioctl_download && ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
      m_dip[int'(ioctl_addr) * 8 +: 8] = ioctl_dout;

    rise = ioctl_download && !m_prev_dl;
    fall = !ioctl_download && m_prev_dl;
    m_prev_dl = ioctl_download;
    if (rise) begin
      m_loading = 1'b1; m_draining = 1'b0; m_hold_left = -1; m_running = 1'b0;
      m_pushed = push_now;
    end else begin
      if (push_now) m_pushed = 1'b1;
      if (fall && m_loading) begin
        m_loading = 1'b0; m_draining = 1'b1;
        if (m_pushed) m_loaded = 1'b1;
      end else if (m_draining) begin
        if (was_empty) begin m_draining = 1'b0; m_hold_left = HOLD; end
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (m_hold_left == 0) begin
        m_hold_left = -1; m_running = m_loaded;
      end
    end
    m_core_reset = m_running ? user_reset : 1'b1;
  endtask

  // Model advances on each rising edge
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: check DUT against model every falling edge, log transfers
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("dn_wr", 64'(dn_wr), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("dn_addr", 64'(dn_addr), 64'(mq[0][23:8]));
        chk("dn_data", 64'(dn_data), 64'(mq[0][7:0]));
      end
      chk("game_id", 64'(game_id), 64'(m_game));
      chk("dip_sw", dip_sw, m_dip);
      chk("core_reset", 64'(core_reset), 64'(m_core_reset));
      chk("rom_loaded", 64'(rom_loaded), 64'(m_loaded));
      chk("fifo_ovf", 64'(fifo_ovf), 64'(m_ovf));
      if (dn_wr && dn_ready) wlog.push_back({dn_addr, dn_data});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all return #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      dn_ready   = ($urandom_range(0, 3) != 0);
      user_reset = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    if (n >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL release_timeout: core_reset still 1 after %0d cycles", n);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [7:0]  t1_dat [4];
    logic [7:0]  cr [5];
    logic [7:0]  idx;
    logic [24:0] a;
    int ns;
    t1_dat = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset values
    tick();
    chk("rst_dn_wr", 64'(dn_wr), 64'd0);
    chk("rst_dn_addr", 64'(dn_addr), 64'd0);
    chk("rst_dn_data", 64'(dn_data), 64'd0);
    chk("rst_game_id", 64'(game_id), 64'd0);
    chk("rst_dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    chk("rst_fifo_ovf", 64'(fifo_ovf), 64'd0);
    reset = 1'b0;
    repeat (5) tick();

    // T1: four ROM bytes, ready always high
    wlog.delete();
    dn_ready = 1'b1;
    start_dl();
    for (int i = 0; i < 4; i++) strobe(8'd0, 25'(i), t1_dat[i]);
    end_dl();
    wait_release(n);
    chk("t1_hold_len", 64'(n), 64'(HOLD + 2));
    chk("t1_rom_loaded", 64'(rom_loaded), 64'd1);
    chk("t1_wr_count", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (wlog.size() > i) chk("t1_wr", 64'(wlog[i]), 64'({16'(i), t1_dat[i]}));

    // T4: game select then ROM load
    start_dl();
    strobe(8'd1, 25'd0, 8'h0D);
    strobe(8'd0, 25'd0, 8'h5A);
    strobe(8'd0, 25'd1, 8'h5B);
    end_dl();
    wait_release(n);
    chk("t4_game_at_release", 64'(game_id), 64'h0D);

    // T3: DIP bank writes, address 8 is outside the bank
    start_dl();
    strobe(8'd254, 25'd0, 8'h0F);
    strobe(8'd254, 25'd2, 8'hA5);
    strobe(8'd254, 25'd8, 8'h00);
    end_dl();
    wait_release(n);
    chk("t3_dip_sw", dip_sw, 64'hFFFF_FFFF_FFA5_FF0F);

    // T5: out-of-range ROM byte, then user reset while running
    start_dl();
    strobe(8'd0, 25'(ROM_SIZE), 8'h77);
    chk("t5_no_wr_a", 64'(dn_wr), 64'd0);
    tick();
    chk("t5_no_wr_b", 64'(dn_wr), 64'd0);
    end_dl();
    wait_release(n);
    repeat (3) tick();
    cr[0] = 8'(core_reset);
    user_reset = 1'b1;
    tick(); cr[1] = 8'(core_reset);
    tick(); cr[2] = 8'(core_reset);
    tick(); user_reset = 1'b0; cr[3] = 8'(core_reset);
    tick(); cr[4] = 8'(core_reset);
    chk("t5_ur_c0", 64'(cr[0]), 64'd0);
    chk("t5_ur_c1", 64'(cr[1]), 64'd1);
    chk("t5_ur_c2", 64'(cr[2]), 64'd1);
    chk("t5_ur_c3", 64'(cr[3]), 64'd1);
    chk("t5_ur_c4", 64'(cr[4]), 64'd0);

    // T2: backpressure with six back-to-back bytes into a four-entry FIFO
    wlog.delete();
    dn_ready = 1'b0;
    start_dl();
    for (int i = 0; i < 6; i++) strobe(8'd0, 25'(i), 8'(8'hA0 + i));
    repeat (14) tick();
    chk("t2_ovf", 64'(fifo_ovf), 64'd1);
    chk("t2_held_wr", 64'(dn_wr), 64'd1);
    chk("t2_held_addr", 64'(dn_addr), 64'd0);
    chk("t2_no_xfer", 64'(wlog.size()), 64'd0);
    dn_ready = 1'b1;
    end_dl();
    wait_release(n);
    chk("t2_wr_count", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (wlog.size() > i) chk("t2_wr", 64'(wlog[i]), 64'({16'(i), 8'(8'hA0 + i)}));

    // Randomized downloads with random backpressure and user resets
    rand_mode = 1'b1;
    for (int d = 0; d < 20; d++) begin
      ns = $urandom_range(1, 12);
      start_dl();
      for (int s = 0; s < ns; s++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: idx = 8'd0;
          6:       idx = 8'd1;
          7:       idx = 8'd254;
          default: idx = 8'($urandom_range(2, 253));
        endcase
        if (idx == 8'd0) begin
          case ($urandom_range(0, 3))
            0:       a = 25'(s);
            1:       a = 25'(ROM_SIZE - 1);
            2:       a = 25'(ROM_SIZE);
            default: a = 25'($urandom_range(0, 33554431));
          endcase
        end else begin
          a = 25'($urandom_range(0, 15));
        end
        strobe(idx, a, 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) tick();
      end
      end_dl();
      repeat ($urandom_range(0, 90)) tick();
    end
    rand_mode = 1'b0;
    dn_ready = 1'b1;
    user_reset = 1'b0;
    repeat (100) tick();

    // T6: reset in the middle of a load with two entries queued
    dn_ready = 1'b0;
    start_dl();
    strobe(8'd254, 25'd1, 8'h00);
    strobe(8'd0, 25'h10, 8'hC1);
    strobe(8'd0, 25'h11, 8'hC2);
    chk("t6_queued", 64'(dn_wr), 64'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_dn_wr", 64'(dn_wr), 64'd0);
    chk("t6_dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_rom_loaded", 64'(rom_loaded), 64'd0);
    chk("t6_fifo_ovf", 64'(fifo_ovf), 64'd0);
    chk("t6_core_reset", 64'(core_reset), 64'd1);
    wlog.delete();
    dn_ready = 1'b1;
    repeat (HOLD + 20) tick();
    chk("t6_idle_core_reset", 64'(core_reset), 64'd1);
    chk("t6_no_xfer", 64'(wlog.size()), 64'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
